// File: rtl/tt_pcounter_pkg.sv
// Shared definitions for the programmable multi-mode counter: mode encodings and default sizes.
package tt_pcounter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/tt_pcounter_if.sv
// Control and status bundle of the counter; master drives controls, slave (the counter) drives status.
interface tt_pcounter_if
  import tt_pcounter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
);

  logic               en;
  mode_e              mode;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc_div;

  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               tick;
  logic               wrap;
  logic               done;
  logic               busy;

  modport master (
    output en, mode, load, load_val, limit, presc_div,
    input  count, dir, tick, wrap, done, busy
  );

  modport slave (
    input  en, mode, load, load_val, limit, presc_div,
    output count, dir, tick, wrap, done, busy
  );

endinterface

// File: rtl/tt_prescaler.sv
// Enable-gated clock divider: pulses step once every (div+1) enabled cycles.
module tt_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               step
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // ">=" rather than "==" so a divider lowered below the running count fires at once
  assign step = en && (cnt_q >= div);

  // next prescaler count: clear, restart after a step, advance or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (step) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // prescaler count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_um_pcounter.sv
// Programmable counter with up/down/ping-pong/one-shot modes, clamped parallel load and prescaler.
module tt_um_pcounter
  import tt_pcounter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic          clk,
  input  logic          rst,
  tt_pcounter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             step_s;
  logic [WIDTH-1:0] inc_s, dec_s;

  tt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .div  (bus.presc_div),
    .step (step_s)
  );

  assign inc_s = count_q + ONE;
  assign dec_s = count_q - ONE;

  // next counter state: load beats step, step beats hold
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      dir_d   = 1'b0;
      done_d  = 1'b0;
    end else if (step_s) begin
      case (bus.mode)
        MODE_UP: begin
          tick_d = 1'b1;
          if (count_q >= bus.limit) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = inc_s;
          end
        end
        MODE_DOWN: begin
          tick_d = 1'b1;
          if (count_q == '0) begin
            count_d = bus.limit;
            wrap_d  = 1'b1;
          end else if (count_q > bus.limit) begin
            count_d = bus.limit;
          end else begin
            count_d = dec_s;
          end
        end
        MODE_PING: begin
          tick_d = 1'b1;
          if (!dir_q) begin
            if (count_q >= bus.limit) begin
              count_d = (bus.limit == '0) ? '0 : bus.limit - ONE;
              dir_d   = 1'b1;
              wrap_d  = 1'b1;
            end else begin
              count_d = inc_s;
            end
          end else begin
            if (count_q == '0) begin
              count_d = (bus.limit == '0) ? '0 : ONE;
              dir_d   = 1'b0;
              wrap_d  = 1'b1;
            end else begin
              count_d = dec_s;
            end
          end
        end
        MODE_ONESHOT: begin
          // done is raised on the step that lands on limit, or on the first step already at/above it
          if (!done_q) begin
            tick_d = 1'b1;
            if (count_q >= bus.limit) begin
              done_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              count_d = inc_s;
              if (inc_s == bus.limit) begin
                done_d = 1'b1;
                wrap_d = 1'b1;
              end else begin
                done_d = 1'b0;
              end
            end
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end
    dir_d = (bus.mode == MODE_PING) ? dir_d : 1'b0;
  end

  // counter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;
  assign bus.busy  = (count_q != bus.limit);

endmodule

// File: tb/tb_tt_um_pcounter.sv
// Directed self-checking bench for tt_um_pcounter (WIDTH=8, PRESC_W=8).
module tb_tt_um_pcounter;
  import tt_pcounter_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tt_pcounter_if #(.WIDTH(8), .PRESC_W(8)) bus ();

  tt_um_pcounter #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.mode = MODE_UP; bus.load = 1'b0;
    bus.load_val = 8'd0; bus.limit = 8'd5; bus.presc_div = 8'd0;
    cyc();
    cyc();
    n_checks++;
    if ({bus.count, bus.dir, bus.tick, bus.wrap, bus.done, bus.busy} !== {8'd0, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset got count=%0d dir=%b tick=%b wrap=%b done=%b busy=%b exp 0 0 0 0 0 1",
               bus.count, bus.dir, bus.tick, bus.wrap, bus.done, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    for (int i = 1; i <= 6; i++) begin
      cyc();
      n_checks++;
      if ({bus.count, bus.tick, bus.wrap} !== {8'((i == 6) ? 0 : i), 1'b1, (i == 6)}) begin
        n_fail++;
        $display("FAIL up_wrap step=%0d got count=%0d tick=%b wrap=%b exp count=%0d tick=1 wrap=%b",
                 i, bus.count, bus.tick, bus.wrap, (i == 6) ? 0 : i, (i == 6));
      end
    end
  endtask

  task automatic test_ping();
    int exp_c[7] = '{1, 2, 3, 2, 1, 0, 1};
    int exp_d[7] = '{0, 0, 0, 1, 1, 1, 0};
    int exp_w[7] = '{0, 0, 0, 1, 0, 0, 1};
    bus.mode = MODE_PING; bus.limit = 8'd3;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_checks++;
      if ({bus.count, bus.dir, bus.wrap} !== {8'(exp_c[i]), 1'(exp_d[i]), 1'(exp_w[i])}) begin
        n_fail++;
        $display("FAIL ping step=%0d got count=%0d dir=%b wrap=%b exp count=%0d dir=%0d wrap=%0d",
                 i, bus.count, bus.dir, bus.wrap, exp_c[i], exp_d[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    bus.mode = MODE_ONESHOT; bus.limit = 8'd4; bus.presc_div = 8'd2;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      cyc();
      n_checks++;
      if ({bus.count, bus.tick, bus.done, bus.busy} !==
          {8'(e / 3), (e % 3 == 0), (e == 12), (e != 12)}) begin
        n_fail++;
        $display("FAIL oneshot edge=%0d got count=%0d tick=%b done=%b busy=%b exp count=%0d tick=%b done=%b busy=%b",
                 e, bus.count, bus.tick, bus.done, bus.busy, e / 3, (e % 3 == 0), (e == 12), (e != 12));
      end
    end
    n_checks++;
    if (bus.wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_wrap got %b exp 1", bus.wrap);
    end
    for (int e = 0; e < 6; e++) begin
      cyc();
      n_checks++;
      if ({bus.count, bus.tick, bus.wrap, bus.done} !== {8'd4, 3'b001}) begin
        n_fail++;
        $display("FAIL oneshot_hold edge=%0d got count=%0d tick=%b wrap=%b done=%b exp 4 0 0 1",
                 e, bus.count, bus.tick, bus.wrap, bus.done);
      end
    end
    bus.load = 1'b1; bus.load_val = 8'd0;
    cyc();
    bus.load = 1'b0;
    n_checks++;
    if ({bus.count, bus.done, bus.tick} !== {8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL oneshot_load got count=%0d done=%b tick=%b exp 0 0 0", bus.count, bus.done, bus.tick);
    end
  endtask

  task automatic test_load_clamp();
    bus.mode = MODE_UP; bus.limit = 8'd200; bus.presc_div = 8'd0;
    do_reset();
    bus.load = 1'b1; bus.load_val = 8'd250;
    cyc();
    bus.load = 1'b0;
    n_checks++;
    if ({bus.count, bus.tick, bus.wrap, bus.busy} !== {8'd200, 3'b000}) begin
      n_fail++;
      $display("FAIL load_clamp got count=%0d tick=%b wrap=%b busy=%b exp 200 0 0 0",
               bus.count, bus.tick, bus.wrap, bus.busy);
    end
    cyc();
    n_checks++;
    if ({bus.count, bus.wrap} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_then_wrap got count=%0d wrap=%b exp 0 1", bus.count, bus.wrap);
    end
    bus.load = 1'b1; bus.load_val = 8'd17;
    cyc();
    bus.load = 1'b0;
    n_checks++;
    if (bus.count !== 8'd17) begin
      n_fail++;
      $display("FAIL load_plain got count=%0d exp 17", bus.count);
    end
  endtask

  task automatic test_limit_lower();
    bus.mode = MODE_UP; bus.limit = 8'd200;
    bus.load = 1'b1; bus.load_val = 8'd9;
    cyc();
    bus.load = 1'b0; bus.limit = 8'd4;
    cyc();
    n_checks++;
    if ({bus.count, bus.tick, bus.wrap} !== {8'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL lower_up got count=%0d tick=%b wrap=%b exp 0 1 1", bus.count, bus.tick, bus.wrap);
    end
    bus.limit = 8'd200; bus.load = 1'b1; bus.load_val = 8'd9;
    cyc();
    bus.load = 1'b0; bus.limit = 8'd4; bus.mode = MODE_DOWN;
    cyc();
    n_checks++;
    if ({bus.count, bus.tick, bus.wrap} !== {8'd4, 2'b10}) begin
      n_fail++;
      $display("FAIL lower_down got count=%0d tick=%b wrap=%b exp 4 1 0", bus.count, bus.tick, bus.wrap);
    end
    cyc();
    n_checks++;
    if (bus.count !== 8'd3) begin
      n_fail++;
      $display("FAIL down_step got count=%0d exp 3", bus.count);
    end
  endtask

  task automatic test_full_range();
    bus.mode = MODE_UP; bus.limit = 8'd255;
    bus.load = 1'b1; bus.load_val = 8'd254;
    cyc();
    bus.load = 1'b0;
    cyc();
    n_checks++;
    if ({bus.count, bus.wrap, bus.busy} !== {8'd255, 2'b00}) begin
      n_fail++;
      $display("FAIL full_top got count=%0d wrap=%b busy=%b exp 255 0 0", bus.count, bus.wrap, bus.busy);
    end
    cyc();
    n_checks++;
    if ({bus.count, bus.wrap, bus.busy} !== {8'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL full_wrap got count=%0d wrap=%b busy=%b exp 0 1 1", bus.count, bus.wrap, bus.busy);
    end
  endtask

  task automatic test_rst_freeze();
    bus.mode = MODE_PING; bus.limit = 8'd3; bus.presc_div = 8'd0;
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if ({bus.count, bus.dir} !== {8'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_rst got count=%0d dir=%b exp 2 1", bus.count, bus.dir);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({bus.count, bus.dir, bus.done} !== {8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_rst got count=%0d dir=%b done=%b exp 0 0 0", bus.count, bus.dir, bus.done);
    end
    bus.mode = MODE_UP; bus.limit = 8'd50;
    for (int i = 0; i < 3; i++) cyc();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if ({bus.count, bus.tick, bus.wrap} !== {8'd3, 2'b00}) begin
        n_fail++;
        $display("FAIL freeze cyc=%0d got count=%0d tick=%b wrap=%b exp 3 0 0", i, bus.count, bus.tick, bus.wrap);
      end
    end
    bus.en = 1'b1;
    cyc();
    n_checks++;
    if ({bus.count, bus.tick} !== {8'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL unfreeze got count=%0d tick=%b exp 4 1", bus.count, bus.tick);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_up_wrap();
    test_ping();
    test_oneshot();
    test_load_clamp();
    test_limit_lower();
    test_full_range();
    test_rst_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
